// File: rtl/bin2rns_mod_lut.sv
// Binary-to-residue converter for the fixed moduli set {8,7,5,3}.
// The signed 10-bit input is converted to four registered residues with one cycle of latency.
module bin2rns_mod_lut (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] n,
   output logic [2:0] mod8,
   output logic [2:0] mod7,
   output logic [2:0] mod5,
   output logic [1:0] mod3
);

   logic [2:0] mod8_q, mod8_d;
   logic [2:0] mod7_q, mod7_d;
   logic [2:0] mod5_q, mod5_d;
   logic [1:0] mod3_q, mod3_d;

   // Each residue folds the raw code as an unsigned value using 2^k == 1 (mod m).
   // The signed value is code - 1024*sign, so the sign bit adds the residue of -1024.
   function automatic logic [2:0] res7(input logic [9:0] v);
      logic [4:0] s;
      logic [3:0] f;
      logic [3:0] c;
      s = {2'b00, v[2:0]} + {2'b00, v[5:3]} + {2'b00, v[8:6]} + {4'b0000, v[9]};
      f = {1'b0, s[2:0]} + {2'b00, s[4:3]};
      if (f >= 4'd7) f = f - 4'd7;
      c = f + (v[9] ? 4'd5 : 4'd0);
      if (c >= 4'd7) c = c - 4'd7;
      return 3'(c);
   endfunction

   function automatic logic [2:0] res5(input logic [9:0] v);
      logic [5:0] s;
      logic [4:0] f1;
      logic [4:0] f2;
      s  = {2'b00, v[3:0]} + {2'b00, v[7:4]} + {4'b0000, v[9:8]};
      f1 = {1'b0, s[3:0]} + {3'b000, s[5:4]};
      f2 = {1'b0, f1[3:0]} + {4'b0000, f1[4]};
      if (f2 >= 5'd10) f2 = f2 - 5'd10;
      if (f2 >= 5'd5) f2 = f2 - 5'd5;
      f2 = f2 + (v[9] ? 5'd1 : 5'd0);
      if (f2 >= 5'd5) f2 = f2 - 5'd5;
      return 3'(f2);
   endfunction

   function automatic logic [1:0] res3(input logic [9:0] v);
      logic [3:0] s;
      logic [2:0] f1;
      logic [2:0] f2;
      s  = {2'b00, v[1:0]} + {2'b00, v[3:2]} + {2'b00, v[5:4]}
         + {2'b00, v[7:6]} + {2'b00, v[9:8]};
      f1 = {1'b0, s[1:0]} + {1'b0, s[3:2]};
      f2 = {1'b0, f1[1:0]} + {2'b00, f1[2]};
      if (f2 >= 3'd3) f2 = f2 - 3'd3;
      f2 = f2 + (v[9] ? 3'd2 : 3'd0);
      if (f2 >= 3'd3) f2 = f2 - 3'd3;
      return 2'(f2);
   endfunction

   // Modulus 8 divides 1024, so the low three bits already are the signed residue.
   always_comb begin
      mod8_d = n[2:0];
      mod7_d = res7(n);
      mod5_d = res5(n);
      mod3_d = res3(n);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod8_q <= 3'd0;
         mod7_q <= 3'd0;
         mod5_q <= 3'd0;
         mod3_q <= 2'd0;
      end else begin
         mod8_q <= mod8_d;
         mod7_q <= mod7_d;
         mod5_q <= mod5_d;
         mod3_q <= mod3_d;
      end
   end

   assign mod8 = mod8_q;
   assign mod7 = mod7_q;
   assign mod5 = mod5_q;
   assign mod3 = mod3_q;

endmodule

// File: tb/tb_bin2rns_mod_lut.sv
// Self-checking bench for bin2rns_mod_lut: directed vectors, full-range sweep,
// random streaming and reset behaviour against an arithmetic residue model.
module tb_bin2rns_mod_lut;

   logic       clk;
   logic       rst_n;
   logic [9:0] n;
   logic [2:0] mod8;
   logic [2:0] mod7;
   logic [2:0] mod5;
   logic [1:0] mod3;

   int checks = 0;
   int failures = 0;

   bin2rns_mod_lut dut (
      .clk   (clk),
      .rst_n (rst_n),
      .n     (n),
      .mod8  (mod8),
      .mod7  (mod7),
      .mod5  (mod5),
      .mod3  (mod3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Least non-negative residue of the signed code, packed as {mod8,mod7,mod5,mod3}.
   function automatic logic [10:0] model(input logic [9:0] code);
      int v;
      int r8, r7, r5, r3;
      v  = int'($signed(code));
      r8 = ((v % 8) + 8) % 8;
      r7 = ((v % 7) + 7) % 7;
      r5 = ((v % 5) + 5) % 5;
      r3 = ((v % 3) + 3) % 3;
      return {3'(r8), 3'(r7), 3'(r5), 2'(r3)};
   endfunction

   function automatic logic [10:0] observed();
      return {mod8, mod7, mod5, mod3};
   endfunction

   task automatic test_reset;
      logic [10:0] got;
      rst_n = 1'b1;
      n = 10'd0;
      #2;
      rst_n = 1'b0;
      n = 10'h3FF;
      #1;
      got = observed();
      checks++;
      if (got !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_immediate got=%h exp=%h", got, 11'd0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_held got=%h exp=%h", got, 11'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== {3'd7, 3'd6, 3'd4, 2'd2}) begin
         failures++;
         $display("[TB] FAIL reset_release got=%h exp=%h", got, {3'd7, 3'd6, 3'd4, 2'd2});
      end
   endtask

   task automatic test_directed;
      logic [9:0]  codes [8];
      logic [10:0] exps  [8];
      logic [10:0] got;
      codes = '{10'd0, 10'd100, 10'd419, 10'h3FF, 10'h25C, 10'h397, 10'h1FF, 10'h200};
      exps  = '{{3'd0, 3'd0, 3'd0, 2'd0}, {3'd4, 3'd2, 3'd0, 2'd1},
                {3'd3, 3'd6, 3'd4, 2'd2}, {3'd7, 3'd6, 3'd4, 2'd2},
                {3'd4, 3'd0, 3'd0, 2'd0}, {3'd7, 3'd0, 3'd0, 2'd0},
                {3'd7, 3'd0, 3'd1, 2'd1}, {3'd0, 3'd6, 3'd3, 2'd1}};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n = codes[i];
         @(negedge clk);
         got = observed();
         checks++;
         if (got !== exps[i]) begin
            failures++;
            $display("[TB] FAIL directed n=%h got=%h exp=%h", codes[i], got, exps[i]);
         end
      end
   endtask

   task automatic test_sweep;
      logic [9:0]  prev;
      logic [10:0] got;
      prev = 10'd0;
      for (int v = -420; v <= 420; v++) begin
         @(negedge clk);
         if (v > -420) begin
            got = observed();
            checks++;
            if (got !== model(prev)) begin
               failures++;
               $display("[TB] FAIL sweep n=%h got=%h exp=%h", prev, got, model(prev));
            end
         end
         if (v <= 419) begin
            n = 10'(v);
            prev = 10'(v);
         end
      end
   endtask

   task automatic test_back_to_back_random;
      logic [9:0]  prev;
      logic [10:0] got;
      prev = 10'd0;
      for (int i = 0; i <= 200; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = observed();
            checks++;
            if (got !== model(prev)) begin
               failures++;
               $display("[TB] FAIL random n=%h got=%h exp=%h", prev, got, model(prev));
            end
         end
         prev = 10'($urandom_range(0, 1023));
         n = prev;
      end
   endtask

   task automatic test_reset_midsweep;
      logic [9:0]  prev;
      logic [10:0] got;
      logic [10:0] exp;
      prev = 10'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i > 0) begin
            exp = (i >= 11 && i <= 13) ? 11'd0 : model(prev);
            got = observed();
            checks++;
            if (got !== exp) begin
               failures++;
               $display("[TB] FAIL midsweep i=%0d n=%h got=%h exp=%h", i, prev, got, exp);
            end
         end
         if (i == 10) begin
            rst_n = 1'b0;
            #1;
            got = observed();
            checks++;
            if (got !== 11'd0) begin
               failures++;
               $display("[TB] FAIL midsweep_assert got=%h exp=%h", got, 11'd0);
            end
         end
         if (i == 13) rst_n = 1'b1;
         prev = 10'($urandom_range(0, 1023));
         n = prev;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_sweep();
      test_back_to_back_random();
      test_reset_midsweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
